color_fill_writer: RTL and testbench
====================================

# color_fill_writer

Consumer side of the color-change handshake: accepts a 16-bit RGB565 color with a single-cycle strobe and paints the whole display panel that color over a 4-wire SPI link (CS, SCK, MOSI, D/C). It sits between the color-change logic and the LCD pins. It issues a memory-write command byte, then streams H_PIXELS×V_PIXELS pixels of two bytes each. A single-entry pending slot absorbs colors that arrive mid-fill.

## Interface
- H_PIXELS, 240, panel width in pixels (≥1)
- V_PIXELS, 240, panel height in pixels (≥1)
- CLK_DIV, 2, SCK half-period in clock cycles (≥1)
- RAMWR_CMD, 8'h2C, command byte sent with dc=0 at the start of every fill
- clock  input  1  system clock; all logic on posedge
- reset_n  input  1  asynchronous, active-low reset
- color_valid  input  1  color strobe; sampled every cycle
- color  input  16  RGB565 color, valid when color_valid=1
- busy  output  1  fill in progress (command, pixel or DONE cycle)
- frame_done  output  1  one-cycle pulse when a fill completes
- spi_cs_n  output  1  panel chip select, active low
- spi_sck  output  1  SPI clock, mode 0 (idle low, sample on rise)
- spi_mosi  output  1  serial data, MSB first
- spi_dc  output  1  0 = command byte, 1 = pixel data

## Operation
- Reset (asynchronous, takes effect immediately):
  - FSM goes to IDLE; pending slot is empty.
  - Outputs: busy=0, frame_done=0, spi_cs_n=1, spi_sck=0, spi_mosi=0, spi_dc=0.
  - Internal counters and the active color clear to 0.
- FSM states: IDLE, CMD, PIX_HI, PIX_LO, DONE.
- IDLE:
  - color_valid=1 latches color into the active color register; next state is CMD.
  - Otherwise stay in IDLE.
- CMD: shift RAMWR_CMD with dc=0, then go to PIX_HI.
- PIX_HI: shift active[15:8] with dc=1, then go to PIX_LO.
- PIX_LO: shift active[7:0] with dc=1, then increment the pixel counter.
  - If the count reaches H_PIXELS*V_PIXELS, go to DONE.
  - Otherwise go to PIX_HI.
- Pixel counter width is $clog2(H_PIXELS*V_PIXELS+1). It clears on entry to CMD.
- DONE lasts exactly 1 cycle: spi_cs_n=1, frame_done=1, busy=1. It exits as follows:
  - color_valid=1 this cycle: that color becomes active; next state is CMD (overrides any pending color).
  - Else if pending is full: pending becomes active, pending clears; next state is CMD.
  - Else: next state is IDLE.
- color_valid=1 in CMD/PIX_HI/PIX_LO: color is written to the pending slot and marks it full. Later arrivals overwrite it (last color wins). Nothing is ever dropped silently except overwritten intermediates.
- The active color is constant for the whole fill; all pixels of one frame are identical.

## Timing
- color_valid sampled at edge t (IDLE). State is CMD from t+1. spi_cs_n falls and busy rises at t+1.
- Byte serializer:
  - Each bit lasts 2*CLK_DIV cycles: spi_sck low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - spi_mosi changes only while sck is low, at the first cycle of each bit.
  - A byte is 16*CLK_DIV cycles. Bytes are back-to-back with no gap cycles.
  - spi_dc is valid for the whole byte.
- Fill length is B = 1 + 2*H_PIXELS*V_PIXELS bytes, i.e. 16*CLK_DIV*B cycles from t+1.
- DONE occurs at t+1+16*CLK_DIV*B. busy falls the cycle after DONE if the FSM returns to IDLE.
- Back-to-back fills: spi_cs_n is high for exactly the one DONE cycle, and the next command byte starts the following cycle.
- spi_cs_n stays low continuously from the first command bit to the last pixel bit.
- spi_sck is 0 whenever spi_cs_n=1.

## Test plan
- Reset, then idle 20 cycles:
  - Required: spi_cs_n=1, spi_sck=0, spi_mosi=0, spi_dc=0, busy=0, frame_done=0 throughout.
- H=V=2, CLK_DIV=1; pulse color_valid with color=16'hF801 at cycle t:
  - Bytes decoded on sck rises: 2C,F8,01,F8,01,F8,01,F8,01.
  - spi_dc pattern is 0 then 1×8.
  - Exactly one frame_done pulse, at t+145; busy is high t+1..t+145.
- Same setup; send 16'h07E0, then 16'h001F and 16'hFFFF mid-fill:
  - Second fill uses FF,FF only (last color wins).
  - spi_cs_n is high for exactly 1 cycle between fills; a third fill never starts.
- color_valid=1 with 16'hA5A5 in the DONE cycle while pending holds 16'h001F:
  - Next fill streams A5,A5 and the pending slot is discarded.
- Assert reset_n=0 mid-pixel byte:
  - Outputs reach reset values without waiting for a clock edge.
  - After release, the next strobe starts a fill beginning with command byte 2C.
- CLK_DIV=3:
  - SCK period is 6 cycles, with 3 cycles low and 3 high.
  - spi_mosi never changes while sck is high.
  - One byte takes 48 cycles.

Source files
------------

// File: rtl/color_fill_writer.sv
// rtl/color_fill_writer.sv - paints the whole panel one RGB565 color over 4-wire SPI
module color_fill_writer #(
    parameter int         H_PIXELS  = 240,
    parameter int         V_PIXELS  = 240,
    parameter int         CLK_DIV   = 2,
    parameter logic [7:0] RAMWR_CMD = 8'h2C
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        color_valid,
    input  logic [15:0] color,
    output logic        busy,
    output logic        frame_done,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_dc
);

    localparam int             NPIX     = H_PIXELS * V_PIXELS;
    localparam int             PCW      = $clog2(NPIX + 1);
    localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [PCW-1:0] PIX_LAST = PCW'(NPIX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_PIX_HI,
        S_PIX_LO,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next_state;

    logic [DW-1:0]  r_div_cnt;
    logic           r_half;        // 0 = sck low phase, 1 = sck high phase
    logic [2:0]     r_bit_cnt;
    logic [PCW-1:0] r_pix_cnt;
    logic [15:0]    r_active;
    logic [15:0]    r_pend_color;
    logic           r_pend_valid;

    logic           w_shifting;
    logic           w_byte_end;
    logic           w_enter_cmd;
    logic [7:0]     w_cur_byte;

    assign w_shifting  = (r_state == S_CMD) || (r_state == S_PIX_HI) || (r_state == S_PIX_LO);
    assign w_byte_end  = w_shifting && r_half && (r_div_cnt == DIV_LAST) && (r_bit_cnt == 3'd7);
    assign w_enter_cmd = (w_next_state == S_CMD) && (r_state != S_CMD);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a fill only advances on byte boundaries
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (color_valid) w_next_state = S_CMD;
            S_CMD:    if (w_byte_end) w_next_state = S_PIX_HI;
            S_PIX_HI: if (w_byte_end) w_next_state = S_PIX_LO;
            S_PIX_LO: if (w_byte_end) w_next_state = (r_pix_cnt == PIX_LAST) ? S_DONE : S_PIX_HI;
            S_DONE:   w_next_state = (color_valid || r_pend_valid) ? S_CMD : S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Bit timing: CLK_DIV cycles low, CLK_DIV high, 8 bits per byte, bytes back-to-back
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_half    <= 1'b0;
            r_bit_cnt <= 3'd0;
        end else if (!w_shifting) begin
            r_div_cnt <= '0;
            r_half    <= 1'b0;
            r_bit_cnt <= 3'd0;
        end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            r_half    <= ~r_half;
            if (r_half) r_bit_cnt <= r_bit_cnt + 3'd1;
        end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    // Pixel counter restarts at the beginning of every fill
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pix_cnt <= '0;
        end else if (w_enter_cmd) begin
            r_pix_cnt <= '0;
        end else if ((r_state == S_PIX_LO) && w_byte_end) begin
            r_pix_cnt <= r_pix_cnt + PCW'(1);
        end
    end

    // Active color is frozen for a fill; mid-fill colors land in the pending slot
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_active     <= 16'h0000;
            r_pend_color <= 16'h0000;
            r_pend_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (color_valid) r_active <= color;
                end
                S_CMD, S_PIX_HI, S_PIX_LO: begin
                    if (color_valid) begin
                        r_pend_color <= color;
                        r_pend_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (color_valid) begin
                        r_active     <= color;
                        r_pend_valid <= 1'b0;
                    end else if (r_pend_valid) begin
                        r_active     <= r_pend_color;
                        r_pend_valid <= 1'b0;
                    end
                end
                default: begin
                    r_pend_valid <= r_pend_valid;
                end
            endcase
        end
    end

    // Byte currently on the wire
    always_comb begin
        w_cur_byte = 8'h00;
        case (r_state)
            S_CMD:    w_cur_byte = RAMWR_CMD;
            S_PIX_HI: w_cur_byte = r_active[15:8];
            S_PIX_LO: w_cur_byte = r_active[7:0];
            default:  w_cur_byte = 8'h00;
        endcase
    end

    assign busy       = (r_state != S_IDLE);
    assign frame_done = (r_state == S_DONE);
    assign spi_cs_n   = ~w_shifting;
    assign spi_sck    = w_shifting & r_half;
    assign spi_dc     = (r_state == S_PIX_HI) || (r_state == S_PIX_LO);
    assign spi_mosi   = w_shifting & w_cur_byte[3'd7 - r_bit_cnt];

endmodule

// File: tb/tb_color_fill_writer.sv
// tb/tb_color_fill_writer.sv - scoreboard bench for color_fill_writer
module tb_color_fill_writer;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0, rst_b = 1'b0;
    logic        cv_a = 1'b0, cv_b = 1'b0;
    logic [15:0] col_a = 16'h0, col_b = 16'h0;
    logic        busy_a, fd_a, cs_a, sck_a, mosi_a, dc_a;
    logic        busy_b, fd_b, cs_b, sck_b, mosi_b, dc_b;

    always #5 clk = ~clk;

    color_fill_writer #(.H_PIXELS(2), .V_PIXELS(2), .CLK_DIV(1), .RAMWR_CMD(8'h2C)) dut_a (
        .clock(clk), .reset_n(rst_a), .color_valid(cv_a), .color(col_a),
        .busy(busy_a), .frame_done(fd_a), .spi_cs_n(cs_a), .spi_sck(sck_a),
        .spi_mosi(mosi_a), .spi_dc(dc_a)
    );

    color_fill_writer #(.H_PIXELS(1), .V_PIXELS(1), .CLK_DIV(3), .RAMWR_CMD(8'h2C)) dut_b (
        .clock(clk), .reset_n(rst_b), .color_valid(cv_b), .color(col_b),
        .busy(busy_b), .frame_done(fd_b), .spi_cs_n(cs_b), .spi_sck(sck_b),
        .spi_mosi(mosi_b), .spi_dc(dc_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int ncyc     = 0;

    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];

    // monitor state, dut_a
    int         bitn_a = 0, fdcnt_a = 0, lastfd_a = 0, brise_a = 0, bfall_a = 0;
    int         csh_a = 0, gap_a = 0, viol_a = 0;
    logic       seen_low_a = 1'b0;
    logic [7:0] sh_a = 8'h0;
    logic       dor_a = 1'b0, dand_a = 1'b0;
    logic       psck_a = 1'b0, pmosi_a = 1'b0, pbusy_a = 1'b0;

    // monitor state, dut_b
    int         bitn_b = 0, lastfd_b = 0, viol_b = 0, lastbyte_b = 0, bint_b = 0;
    int         run_b = 0, lo_min = 1000, lo_max = 0, hi_min = 1000, hi_max = 0;
    logic [7:0] sh_b = 8'h0;
    logic       dor_b = 1'b0, dand_b = 1'b0;
    logic       psck_b = 1'b0, pmosi_b = 1'b0, pbusy_b = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic sample();
        logic [9:0] e;
        ncyc++;
        // dut_a
        if (cs_a && sck_a) viol_a++;
        if (!cs_a && psck_a == sck_a && !psck_a == 1'b0 && mosi_a != pmosi_a) viol_a++;
        if (!cs_a || !rst_a) begin
            if (!cs_a && !seen_low_a) seen_low_a = 1'b1;
        end
        if (!rst_a || cs_a) begin
            bitn_a = 0;
        end else if (sck_a && !psck_a) begin
            sh_a   = {sh_a[6:0], mosi_a};
            dor_a  = (bitn_a == 0) ? dc_a : (dor_a | dc_a);
            dand_a = (bitn_a == 0) ? dc_a : (dand_a & dc_a);
            bitn_a++;
            if (bitn_a == 8) begin
                bitn_a = 0;
                if (exp_a.size() == 0) begin
                    check("a_extra_byte", 32'(exp_a.size()), 32'd1);
                end else begin
                    e = exp_a.pop_front();
                    check("a_byte", {22'd0, dor_a, dand_a, sh_a}, {22'd0, e});
                end
            end
        end
        if (fd_a) begin fdcnt_a++; lastfd_a = ncyc; end
        if (busy_a && !pbusy_a) brise_a = ncyc;
        if (!busy_a && pbusy_a) bfall_a = ncyc;
        if (cs_a) begin
            csh_a++;
        end else begin
            if (csh_a > 0) gap_a = csh_a;
            csh_a = 0;
        end
        psck_a = sck_a; pmosi_a = mosi_a; pbusy_a = busy_a;
        // dut_b
        if (cs_b && sck_b) viol_b++;
        if (!cs_b && sck_b && psck_b && mosi_b != pmosi_b) viol_b++;
        if (!cs_b && !sck_b && !psck_b && mosi_b != pmosi_b) viol_b++;
        if (!cs_b) begin
            if (sck_b == psck_b || run_b == 0) begin
                run_b++;
            end else begin
                if (psck_b) begin hi_min = (run_b < hi_min) ? run_b : hi_min; hi_max = (run_b > hi_max) ? run_b : hi_max; end
                else begin lo_min = (run_b < lo_min) ? run_b : lo_min; lo_max = (run_b > lo_max) ? run_b : lo_max; end
                run_b = 1;
            end
        end else if (run_b > 0) begin
            if (psck_b) begin hi_min = (run_b < hi_min) ? run_b : hi_min; hi_max = (run_b > hi_max) ? run_b : hi_max; end
            else begin lo_min = (run_b < lo_min) ? run_b : lo_min; lo_max = (run_b > lo_max) ? run_b : lo_max; end
            run_b = 0;
        end
        if (!rst_b || cs_b) begin
            bitn_b = 0;
        end else if (sck_b && !psck_b) begin
            sh_b   = {sh_b[6:0], mosi_b};
            dor_b  = (bitn_b == 0) ? dc_b : (dor_b | dc_b);
            dand_b = (bitn_b == 0) ? dc_b : (dand_b & dc_b);
            bitn_b++;
            if (bitn_b == 8) begin
                bitn_b     = 0;
                bint_b     = ncyc - lastbyte_b;
                lastbyte_b = ncyc;
                if (exp_b.size() == 0) begin
                    check("b_extra_byte", 32'(exp_b.size()), 32'd1);
                end else begin
                    e = exp_b.pop_front();
                    check("b_byte", {22'd0, dor_b, dand_b, sh_b}, {22'd0, e});
                end
            end
        end
        if (fd_b) lastfd_b = ncyc;
        psck_b = sck_b; pmosi_b = mosi_b; pbusy_b = busy_b;
    endtask

    // one clock: sample on the falling edge, return just after the rising edge
    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fill_a(input logic [15:0] c);
        exp_a.push_back({2'b00, 8'h2C});
        for (int i = 0; i < 4; i++) begin
            exp_a.push_back({2'b11, c[15:8]});
            exp_a.push_back({2'b11, c[7:0]});
        end
    endtask

    task automatic strobe_a(input logic [15:0] c);
        cv_a = 1'b1; col_a = c;
        step();
        cv_a = 1'b0;
    endtask

    task automatic wait_idle_a(input int maxc);
        int n = 0;
        step();
        while (pbusy_a && n < maxc) begin step(); n++; end
        check("a_idle_timeout", 32'(pbusy_a), 32'd0);
    endtask

    int t0, fd0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b1; rst_b = 1'b1;

        // reset / idle
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_a", {26'd0, cs_a, sck_a, mosi_a, dc_a, busy_a, fd_a}, 32'b100000);
            check("idle_b", {26'd0, cs_b, sck_b, mosi_b, dc_b, busy_b, fd_b}, 32'b100000);
        end

        // single fill F801
        fd0 = fdcnt_a;
        push_fill_a(16'hF801);
        strobe_a(16'hF801);
        t0 = ncyc;
        wait_idle_a(400);
        check("fill1_done_cycle", 32'(lastfd_a - t0), 32'd145);
        check("fill1_done_count", 32'(fdcnt_a - fd0), 32'd1);
        check("fill1_busy_rise", 32'(brise_a - t0), 32'd1);
        check("fill1_busy_fall", 32'(bfall_a - t0), 32'd146);
        check("fill1_drain", 32'(exp_a.size()), 32'd0);

        // last pending color wins
        fd0 = fdcnt_a;
        push_fill_a(16'h07E0);
        push_fill_a(16'hFFFF);
        strobe_a(16'h07E0);
        repeat (20) step();
        strobe_a(16'h001F);
        repeat (10) step();
        strobe_a(16'hFFFF);
        wait_idle_a(800);
        check("pend_done_count", 32'(fdcnt_a - fd0), 32'd2);
        check("pend_cs_gap", 32'(gap_a), 32'd1);
        check("pend_drain", 32'(exp_a.size()), 32'd0);
        repeat (200) step();
        check("no_third_busy", 32'(busy_a), 32'd0);
        check("no_third_done", 32'(fdcnt_a - fd0), 32'd2);

        // strobe in DONE overrides pending
        fd0 = fdcnt_a;
        push_fill_a(16'hF801);
        push_fill_a(16'hA5A5);
        strobe_a(16'hF801);
        repeat (20) step();
        strobe_a(16'h001F);
        repeat (123) step();
        check("done_cycle_hit", 32'(fd_a), 32'd1);
        strobe_a(16'hA5A5);
        wait_idle_a(800);
        check("ovr_done_count", 32'(fdcnt_a - fd0), 32'd2);
        check("ovr_cs_gap", 32'(gap_a), 32'd1);
        check("ovr_drain", 32'(exp_a.size()), 32'd0);
        repeat (200) step();
        check("ovr_no_third", 32'(fdcnt_a - fd0), 32'd2);

        // asynchronous reset mid pixel byte
        push_fill_a(16'hF801);
        strobe_a(16'hF801);
        repeat (30) step();
        check("pre_reset_cs", 32'(cs_a), 32'd0);
        #2;
        rst_a = 1'b0;
        #1;
        check("async_reset_outs", {26'd0, cs_a, sck_a, mosi_a, dc_a, busy_a, fd_a}, 32'b100000);
        exp_a.delete();
        repeat (3) step();
        rst_a = 1'b1;
        repeat (2) step();
        fd0 = fdcnt_a;
        push_fill_a(16'h1234);
        strobe_a(16'h1234);
        wait_idle_a(400);
        check("post_reset_done", 32'(fdcnt_a - fd0), 32'd1);
        check("post_reset_drain", 32'(exp_a.size()), 32'd0);

        // CLK_DIV=3 single-pixel panel
        exp_b.push_back({2'b00, 8'h2C});
        exp_b.push_back({2'b11, 8'hC3});
        exp_b.push_back({2'b11, 8'hA5});
        cv_b = 1'b1; col_b = 16'hC3A5;
        step();
        cv_b = 1'b0;
        t0 = ncyc;
        begin
            int n = 0;
            step();
            while (pbusy_b && n < 400) begin step(); n++; end
            check("b_idle_timeout", 32'(pbusy_b), 32'd0);
        end
        check("b_done_cycle", 32'(lastfd_b - t0), 32'd145);
        check("b_byte_cycles", 32'(bint_b), 32'd48);
        check("b_sck_low_min", 32'(lo_min), 32'd3);
        check("b_sck_low_max", 32'(lo_max), 32'd3);
        check("b_sck_high_min", 32'(hi_min), 32'd3);
        check("b_sck_high_max", 32'(hi_max), 32'd3);
        check("b_drain", 32'(exp_b.size()), 32'd0);

        check("a_spi_rules", 32'(viol_a), 32'd0);
        check("b_spi_rules", 32'(viol_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
